// File: rtl/sumador_serial_bits_pkg.sv
// ---------------------------------------------------------------------------
// pkg_bits
//   Shared types and widths for the bit-serial adder slice.
//   BITS_WIDTH     : operand width
//   CNT_WIDTH      : width of the serial bit counter
//   bits_t/bitsw_t : operand type and result type (one extra bit for carry-out)
//   cnt_t          : bit counter type
//   serial_state_t : control FSM states
// ---------------------------------------------------------------------------
package pkg_bits;

  localparam int BITS_WIDTH = 4;

  // A 1-bit operand would give $clog2()==0; keep the counter at least 1 bit.
  localparam int CNT_WIDTH = (BITS_WIDTH > 1) ? $clog2(BITS_WIDTH) : 1;

  typedef logic [BITS_WIDTH-1:0] bits_t;
  typedef logic [BITS_WIDTH:0]   bitsw_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } serial_state_t;

endpackage : pkg_bits

// File: rtl/sumador_serial_bits_completo.sv
// ---------------------------------------------------------------------------
// sumador_completo_1b
//   Combinational single-bit full adder, the only arithmetic cell of the
//   bit-serial adder.
//   i_a, i_b, i_cin : input bits and carry-in
//   o_s             : sum bit
//   o_cout          : carry-out (majority of the three inputs)
// ---------------------------------------------------------------------------
module sumador_completo_1b (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule : sumador_completo_1b

// File: rtl/sumador_serial_bits.sv
// ---------------------------------------------------------------------------
// sumador_serial_bits
//   Bit-serial unsigned adder: result = a + b + cin, one bit per clock, LSB
//   first, using a single full-adder cell. Valid/ready handshake on both the
//   operand side and the result side.
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active-high
//   valid_i  : operands valid            ready_o  : can accept (IDLE)
//   a_i, b_i : operands (bits_t)         cin_i    : carry-in
//   valid_o  : result valid (DONE)       ready_i  : downstream accepts result
//   result_o : {carry_out, sum}          busy_o   : serial addition running
// ---------------------------------------------------------------------------
module sumador_serial_bits
  import pkg_bits::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   valid_i,
  output logic   ready_o,
  input  bits_t  a_i,
  input  bits_t  b_i,
  input  logic   cin_i,
  output logic   valid_o,
  input  logic   ready_i,
  output bitsw_t result_o,
  output logic   busy_o
);

  serial_state_t r_state;
  serial_state_t w_state_next;

  bits_t  r_a;
  bits_t  r_b;
  logic   r_c;
  bits_t  r_sum;
  cnt_t   r_cnt;
  bitsw_t r_result;

  logic w_s;
  logic w_cout;
  logic w_accept;
  logic w_last;

  sumador_completo_1b u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_c),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  assign w_accept = valid_i && ready_o;
  assign w_last   = (r_cnt == cnt_t'(BITS_WIDTH - 1));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    ready_o      = 1'b0;
    valid_o      = 1'b0;
    busy_o       = 1'b0;
    case (r_state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy_o = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand shift registers, carry, partial sum, counter, result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= 1'b0;
      r_sum    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a   <= a_i;
            r_b   <= b_i;
            r_c   <= cin_i;
            r_sum <= '0;
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_cout;
          // Sum bits enter at the MSB so after BITS_WIDTH steps the first
          // computed bit has walked down to bit 0.
          r_sum <= {w_s, r_sum[BITS_WIDTH-1:1]};
          r_cnt <= r_cnt + cnt_t'(1);
          if (w_last) begin
            // The final bit is folded in directly rather than waiting a
            // cycle for r_sum to update.
            r_result <= {w_cout, w_s, r_sum[BITS_WIDTH-1:1]};
          end
        end
        default: begin
          // DONE: hold everything; result_o stays stable under backpressure.
        end
      endcase
    end
  end

  assign result_o = r_result;

endmodule : sumador_serial_bits

// File: tb/tb_sumador_serial_bits.sv
module tb_sumador_serial_bits;
  import pkg_bits::*;

  logic   clk;
  logic   rst;
  logic   valid_i;
  logic   ready_o;
  bits_t  a_i;
  bits_t  b_i;
  logic   cin_i;
  logic   valid_o;
  logic   ready_i;
  bitsw_t result_o;
  logic   busy_o;

  int n_checks;
  int n_errors;

  sumador_serial_bits dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .a_i      (a_i),
    .b_i      (b_i),
    .cin_i    (cin_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands while IDLE; they are taken on the next edge.
  task automatic start_op(input bits_t a, input bits_t b, input logic cin);
    valid_i = 1'b1;
    a_i     = a;
    b_i     = b;
    cin_i   = cin;
    step();
    valid_i = 1'b0;
    a_i     = ~a;   // operands may change once latched
    b_i     = ~b;
    cin_i   = ~cin;
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    int n = 0;
    while (!valid_o && n < max_cycles) begin
      step();
      n++;
    end
    check(tag, {31'd0, valid_o}, 32'd1);
  endtask

  // Full transfer with ready_i=1; ends one cycle after handshake (IDLE).
  task automatic run_op(input string tag, input bits_t a, input bits_t b,
                        input logic cin, input bitsw_t expected);
    ready_i = 1'b1;
    start_op(a, b, cin);
    wait_valid({tag, "_timeout"}, 20);
    check(tag, {27'd0, result_o}, {27'd0, expected});
    step();
  endtask

  initial begin
    bitsw_t exp_sum;
    bitsw_t held;
    int     stall;

    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    valid_i  = 1'b0;
    ready_i  = 1'b0;
    a_i      = '0;
    b_i      = '0;
    cin_i    = 1'b0;

    // Reset state
    #1;
    check("rst_ready_o", {31'd0, ready_o}, 32'd1);
    check("rst_valid_o", {31'd0, valid_o}, 32'd0);
    check("rst_busy_o", {31'd0, busy_o}, 32'd0);
    check("rst_result_o", {27'd0, result_o}, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // 1: 7 + 9 + 0 = 0x10, valid exactly 4 edges after accept
    ready_i = 1'b1;
    check("t1_ready_idle", {31'd0, ready_o}, 32'd1);
    start_op(4'h7, 4'h9, 1'b0);
    check("t1_busy", {31'd0, busy_o}, 32'd1);
    check("t1_ready_busy", {31'd0, ready_o}, 32'd0);
    step();
    step();
    step();
    check("t1_valid_early", {31'd0, valid_o}, 32'd0);
    step();
    check("t1_valid", {31'd0, valid_o}, 32'd1);
    check("t1_result", {27'd0, result_o}, 32'h10);
    check("t1_busy_done", {31'd0, busy_o}, 32'd0);
    step();
    check("t1_ready_back", {31'd0, ready_o}, 32'd1);
    check("t1_valid_drop", {31'd0, valid_o}, 32'd0);

    // 2: boundary operands
    run_op("t2_max", 4'hF, 4'hF, 1'b1, 5'h1F);
    run_op("t2_zero", 4'h0, 4'h0, 1'b0, 5'h00);
    run_op("t2_carry", 4'h8, 4'h8, 1'b0, 5'h10);

    // 3: backpressure, 3 + 4 = 0x07 held for 5 cycles
    ready_i = 1'b0;
    start_op(4'h3, 4'h4, 1'b0);
    wait_valid("t3_timeout", 20);
    check("t3_result", {27'd0, result_o}, 32'h07);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_hold_valid", {31'd0, valid_o}, 32'd1);
      check("t3_hold_result", {27'd0, result_o}, 32'h07);
    end
    ready_i = 1'b1;
    step();
    check("t3_xfer_valid", {31'd0, valid_o}, 32'd0);
    check("t3_xfer_ready", {31'd0, ready_o}, 32'd1);
    step();
    check("t3_single_xfer", {31'd0, valid_o}, 32'd0);

    // 4: valid_i held high with new operands during SHIFT/DONE
    ready_i = 1'b1;
    valid_i = 1'b1;
    a_i     = 4'h2;
    b_i     = 4'h5;
    cin_i   = 1'b0;
    step();
    a_i = 4'h1;
    b_i = 4'h1;
    step();
    step();
    step();
    check("t4_not_done", {31'd0, valid_o}, 32'd0);
    step();
    check("t4_valid", {31'd0, valid_o}, 32'd1);
    check("t4_result", {27'd0, result_o}, 32'h07);
    step();
    check("t4_idle_ready", {31'd0, ready_o}, 32'd1);
    check("t4_idle_busy", {31'd0, busy_o}, 32'd0);
    step();
    check("t4_accept2", {31'd0, busy_o}, 32'd1);
    valid_i = 1'b0;
    wait_valid("t4_timeout2", 20);
    check("t4_result2", {27'd0, result_o}, 32'h02);
    step();

    // 5: async reset in the middle of SHIFT
    start_op(4'h9, 4'h9, 1'b0);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("t5_ready", {31'd0, ready_o}, 32'd1);
    check("t5_busy", {31'd0, busy_o}, 32'd0);
    check("t5_valid", {31'd0, valid_o}, 32'd0);
    check("t5_result", {27'd0, result_o}, 32'h00);
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t5_no_valid", {31'd0, valid_o}, 32'd0);
    end
    run_op("t5_after", 4'h5, 4'h6, 1'b0, 5'h0B);

    // 6: exhaustive sweep with random result stalls
    for (int k = 0; k < 512; k++) begin
      exp_sum = bitsw_t'(k[3:0]) + bitsw_t'(k[7:4]) + bitsw_t'(k[8]);
      stall   = $urandom_range(0, 3);
      ready_i = (stall == 0);
      start_op(bits_t'(k[3:0]), bits_t'(k[7:4]), k[8]);
      wait_valid("t6_timeout", 20);
      held = result_o;
      check($sformatf("t6_sum_%0d", k), {27'd0, result_o}, {27'd0, exp_sum});
      if (stall != 0) begin
        for (int j = 0; j < stall; j++) begin
          step();
        end
        check("t6_stall_hold", {27'd0, result_o}, {27'd0, held});
        check("t6_stall_valid", {31'd0, valid_o}, 32'd1);
        ready_i = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_sumador_serial_bits
